// File: rtl/word_transposer_pkg.sv
// Shared constants, state encoding and plane-index helper for the word transposer
// and the bit-plane collector bench.
package word_transposer_pkg;

  localparam int NUM_WORDS = 64;
  localparam int WORD_W    = 25;
  localparam int ADDR_W    = 6;
  localparam int NUM_W     = 32;
  localparam int PLANE_W   = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Plane k carries word bit (WORD_W-1-k): MSB plane first.
  function automatic logic [PLANE_W-1:0] plane_bit(input logic [PLANE_W-1:0] k);
    return PLANE_W'(WORD_W - 1) - k;
  endfunction

endpackage

// File: rtl/word_transposer_bit_plane_select.sv
// Combinational column extract: bit bit_idx of every word, packed word 0 at LSB.
module bit_plane_select
  import word_transposer_pkg::*;
(
  input  logic [WORD_W-1:0]    words [NUM_WORDS],
  input  logic [PLANE_W-1:0]   bit_idx,
  output logic [NUM_WORDS-1:0] column
);

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_col
    assign column[gi] = words[gi][bit_idx];
  end

endmodule

// File: rtl/word_transposer.sv
// Loads NUM_WORDS words, then emits them as WORD_W bit-planes (MSB first) with a final dump strobe.
// Optional macro WORD_TRANSPOSER_HOLD_EN adds a hold input that stalls plane emission.
module word_transposer
  import word_transposer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 start,
`ifdef WORD_TRANSPOSER_HOLD_EN
  input  logic                 hold,
`endif
  output logic                 busy,
  output logic                 ldn,
  output logic [NUM_W-1:0]     number,
  output logic [NUM_WORDS-1:0] n_out,
  output logic                 write_to_file,
  output logic                 done
);

  state_t               state_reg, state_next;
  logic [PLANE_W-1:0]   k_reg, k_next;
  logic                 busy_reg, busy_next;
  logic                 ldn_reg, ldn_next;
  logic [NUM_W-1:0]     number_reg, number_next;
  logic [NUM_WORDS-1:0] n_out_reg, n_out_next;
  logic                 wtf_reg, wtf_next;
  logic                 done_reg, done_next;
  logic                 hold_eff;
  logic [WORD_W-1:0]    words [NUM_WORDS];
  logic [NUM_WORDS-1:0] column;

`ifdef WORD_TRANSPOSER_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  // Memory only accepts writes in IDLE so an in-flight plane sequence stays coherent.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    logic [WORD_W-1:0] word_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        word_reg <= '0;
      else if (wr_en && (state_reg == IDLE) && (wr_addr == ADDR_W'(gi)))
        word_reg <= wr_data;
    end
    assign words[gi] = word_reg;
  end

  bit_plane_select u_select (
    .words   (words),
    .bit_idx (plane_bit(k_reg)),
    .column  (column)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      k_reg      <= '0;
      busy_reg   <= 1'b0;
      ldn_reg    <= 1'b0;
      number_reg <= '0;
      n_out_reg  <= '0;
      wtf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      busy_reg   <= busy_next;
      ldn_reg    <= ldn_next;
      number_reg <= number_next;
      n_out_reg  <= n_out_next;
      wtf_reg    <= wtf_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    busy_next   = busy_reg;
    ldn_next    = 1'b0;
    number_next = number_reg;
    n_out_next  = n_out_reg;
    wtf_next    = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          state_next = EMIT;
          k_next     = '0;
          busy_next  = 1'b1;
        end
      end
      EMIT: begin
        busy_next = 1'b1;
        if (!hold_eff) begin
          ldn_next    = 1'b1;
          number_next = {{(NUM_W - PLANE_W){1'b0}}, k_reg};
          n_out_next  = column;
          if (k_reg == PLANE_W'(WORD_W - 1))
            state_next = FLUSH;
          else
            k_next = k_reg + 1'b1;
        end
      end
      FLUSH: begin
        busy_next  = 1'b1;
        wtf_next   = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = busy_reg;
  assign ldn           = ldn_reg;
  assign number        = number_reg;
  assign n_out         = n_out_reg;
  assign write_to_file = wtf_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_word_transposer.sv
// Directed bench for word_transposer: plane contents, timing, write gating, async reset abort.
// Exercises WORD_TRANSPOSER_HOLD_EN stalls when that macro is defined.
module tb_word_transposer;
  import word_transposer_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 wr_en = 1'b0;
  logic [ADDR_W-1:0]    wr_addr = '0;
  logic [WORD_W-1:0]    wr_data = '0;
  logic                 start = 1'b0;
  logic                 busy, ldn, write_to_file, done;
  logic [NUM_W-1:0]     number;
  logic [NUM_WORDS-1:0] n_out;
`ifdef WORD_TRANSPOSER_HOLD_EN
  logic                 hold = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [WORD_W-1:0] model [NUM_WORDS];
  logic [WORD_W-1:0] col   [NUM_WORDS];

  word_transposer dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
`ifdef WORD_TRANSPOSER_HOLD_EN
    .hold          (hold),
`endif
    .busy          (busy),
    .ldn           (ldn),
    .number        (number),
    .n_out         (n_out),
    .write_to_file (write_to_file),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_plane(input int p);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NUM_WORDS; i++) v[i] = model[i][WORD_W-1-p];
    return v;
  endfunction

  task automatic write_word(input int a, input logic [WORD_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // Called #1 after the start edge; checks 25 planes, the flush cycle and the return to idle.
  task automatic emit_run(input string tag, input int start_at, input int wr_at, input bit keep_start);
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    check({tag, " ldn_after_start"}, 64'(ldn), 64'd0);
    for (int i = 0; i < NUM_WORDS; i++) col[i] = '0;
    for (int p = 0; p < WORD_W; p++) begin
      tick();
      check($sformatf("%s ldn_p%0d", tag, p), 64'(ldn), 64'd1);
      check($sformatf("%s number_p%0d", tag, p), 64'(number), 64'(p));
      check($sformatf("%s n_out_p%0d", tag, p), n_out, model_plane(p));
      for (int i = 0; i < NUM_WORDS; i++) col[i][WORD_W-1-p] = n_out[i];
      if (!keep_start) start = (p == start_at);
      wr_en = (p == wr_at); wr_addr = 6'd5; wr_data = '0;
    end
    if (!keep_start) start = 1'b0;
    wr_en = 1'b0;
    tick();
    check({tag, " wtf"}, 64'(write_to_file), 64'd1);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_flush"}, 64'(busy), 64'd1);
    check({tag, " ldn_flush"}, 64'(ldn), 64'd0);
    check({tag, " number_hold"}, 64'(number), 64'd24);
    tick();
    check({tag, " busy_end"}, 64'(busy), 64'(keep_start));
    check({tag, " done_end"}, 64'(done), 64'd0);
    check({tag, " wtf_end"}, 64'(write_to_file), 64'd0);
    $display("run %s: 25 planes, done 26 cycles after start", tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " ldn"}, 64'(ldn), 64'd0);
    check({tag, " wtf"}, 64'(write_to_file), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " number"}, 64'(number), 64'd0);
    check({tag, " n_out"}, n_out, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int seen_wtf;
    for (int i = 0; i < NUM_WORDS; i++) model[i] = '0;
    #2;
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();

    // All-zero memory.
    pulse_start();
    emit_run("zero", -1, -1, 1'b0);

    // Corner words: plane 0 and plane 24 hand-computed.
    write_word(0, 25'h1000000);
    write_word(63, 25'h0000001);
    pulse_start();
    check("corner busy", 64'(busy), 64'd1);
    tick();
    check("corner plane0", n_out, 64'h0000_0000_0000_0001);
    for (int p = 1; p < WORD_W - 1; p++) begin
      tick();
      check($sformatf("corner plane%0d", p), n_out, 64'd0);
    end
    tick();
    check("corner plane24", n_out, 64'h8000_0000_0000_0000);
    check("corner number24", 64'(number), 64'd24);
    tick();
    check("corner done", 64'(done), 64'd1);
    tick();
    $display("run corner: planes 0 and 24 carry the edge words");

    // word[i]=i, collector reconstruction; a start pulse mid-run is ignored.
    for (int i = 0; i < NUM_WORDS; i++) write_word(i, WORD_W'(i));
    pulse_start();
    emit_run("ramp", 3, -1, 1'b0);
    for (int i = 0; i < NUM_WORDS; i++)
      check($sformatf("collector%0d", i), 64'(col[i]), 64'(i));

    // Write and start together; a write during EMIT must not disturb later planes.
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 25'h1555555; start = 1'b1;
    model[5] = 25'h1555555;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("same_cycle plane0_pre", 64'(busy), 64'd1);
    tick();
    check("same_cycle plane0", n_out, 64'h0000_0000_0000_0020);
    check("same_cycle number0", 64'(number), 64'd0);
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = '0;
    tick();
    wr_en = 1'b0;
    for (int p = 1; p < WORD_W; p++) begin
      if (p > 1) tick();
      check($sformatf("busy_write plane%0d", p), n_out, model_plane(p));
    end
    tick();
    check("busy_write done", 64'(done), 64'd1);
    tick();
    $display("run same_cycle: write landed before plane 0, busy write ignored");

    // Async reset at plane 10 abandons the sequence.
    pulse_start();
    for (int p = 0; p <= 10; p++) tick();
    check("abort number10", 64'(number), 64'd10);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    for (int i = 0; i < NUM_WORDS; i++) model[i] = '0;
    tick();
    rst = 1'b1;
    seen_wtf = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (write_to_file) seen_wtf++;
    end
    check("abort no_wtf", 64'(seen_wtf), 64'd0);
    pulse_start();
    emit_run("post_abort", -1, -1, 1'b0);

`ifdef WORD_TRANSPOSER_HOLD_EN
    write_word(7, 25'h1FFFFFF);
    pulse_start();
    for (int p = 0; p <= 7; p++) tick();
    check("hold number7", 64'(number), 64'd7);
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      check($sformatf("hold ldn%0d", h), 64'(ldn), 64'd0);
      check($sformatf("hold number%0d", h), 64'(number), 64'd7);
    end
    hold = 1'b0;
    for (int p = 8; p < WORD_W; p++) begin
      tick();
      check($sformatf("hold resume_number%0d", p), 64'(number), 64'(p));
      check($sformatf("hold resume_n_out%0d", p), n_out, model_plane(p));
    end
    tick();
    check("hold done29", 64'(done), 64'd1);
    tick();
    $display("run hold: 3-cycle stall at plane 7, done at cycle 29");
`endif

    // Start held across done restarts on the IDLE cycle.
    write_word(9, 25'h0AAAAAA);
    start = 1'b1;
    tick();
    emit_run("restart", -1, -1, 1'b1);
    start = 1'b0;
    tick();
    check("restart ldn", 64'(ldn), 64'd1);
    check("restart number0", 64'(number), 64'd0);
    for (int c = 0; c < WORD_W; c++) tick();
    check("restart done", 64'(done), 64'd1);
    tick();
    check("restart idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/word_transposer.md
Name: word_transposer

Overview:
- Upstream stage of the bit-plane output collector.
- Holds 64 result words of 25 bits, loaded one word per cycle.
- On start, emits the words as 25 bit-planes, MSB first, as ldn / number / n_out.
- Finishes with a one-cycle write_to_file strobe so the collector dumps its registers.

Parameters:
- NUM_WORDS, 64, words held; also n_out width.
- WORD_W, 25, bits per word; also the number of planes emitted.
- ADDR_W, 6, width of wr_addr (log2 NUM_WORDS).
- NUM_W, 32, width of the number output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- wr_en  in  1  write wr_data into word wr_addr.
- wr_addr  in  ADDR_W  word index.
- wr_data  in  WORD_W  word value.
- start  in  1  begin plane emission.
- busy  out  1  high from start acceptance through the write_to_file cycle.
- ldn  out  1  plane valid strobe to the collector.
- number  out  NUM_W  plane index k; plane k carries word bit (WORD_W-1-k).
- n_out  out  NUM_WORDS  n_out[i] = word[i][WORD_W-1-number].
- write_to_file  out  1  one-cycle dump strobe.
- done  out  1  one-cycle completion pulse, coincident with write_to_file.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all words cleared to 0.
  - busy, ldn, write_to_file, done = 0; number=0; n_out=0.
- Every output is registered.
- IDLE:
  - wr_en=1 writes word[wr_addr] at the clock edge.
  - start=1 moves to EMIT with plane counter k=0; busy=1 from the next cycle.
- EMIT, one plane per cycle:
  - Registered outputs: ldn=1, number=k, n_out as defined above.
  - First ldn appears 1 cycle after the start edge.
  - k increments by 1 per cycle.
  - After k=WORD_W-1 (24), move to FLUSH.
  - Exactly 25 consecutive ldn cycles, number 0..24.
- FLUSH, one cycle:
  - ldn=0, write_to_file=1, done=1, busy=1.
  - Next state IDLE; busy=0 the following cycle.
  - Total: start edge to done = 26 cycles.
- Outside EMIT: ldn=0, and n_out/number hold their last values.
- Simultaneous wr_en and start in IDLE: the write lands first, so plane 0 already reflects it.
- wr_en while busy: ignored, memory unchanged.
- start while busy: ignored, no restart.
- start held high across done: restarts immediately on the IDLE cycle.
- Out-of-range wr_addr: impossible, since ADDR_W exactly spans NUM_WORDS.
- Reset mid-EMIT: immediate return to IDLE with all outputs 0. A partial plane sequence is abandoned and write_to_file is never asserted.
- number is zero-extended from the 5-bit plane counter.

Optional Feature:
- Macro: WORD_TRANSPOSER_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit).
  - hold=1 during EMIT: ldn=0 that cycle and k does not advance. Emission resumes at the same k when hold drops.
  - hold during FLUSH or IDLE has no effect.
  - Latency becomes 26 + held cycles.
- Undefined: no hold port; emission is always contiguous.

Decomposition:
- Shared package word_transposer_pkg:
  - NUM_WORDS, WORD_W, ADDR_W, NUM_W constants.
  - State enum {IDLE, EMIT, FLUSH}.
  - Used also by the collector bench.
- One sub-module, bit_plane_select: combinational. Takes the word array and bit index, returns the NUM_WORDS-bit column. The top registers its output into n_out.

Test Plan:
- Reset then start with all words 0 -> 25 ldn pulses, number 0..24, n_out=0 each. Then write_to_file=done=1 at cycle 26, busy low at cycle 27.
- Write word[0]=25'h1000000, word[63]=25'h0000001, then start:
  - Plane 0: n_out = 64'h0000_0000_0000_0001.
  - Plane 24: n_out = 64'h8000_0000_0000_0000.
  - All other planes: 0.
- Write word[i]=i for i=0..63 and connect to the collector -> collector register i ends equal to i for all 64 entries.
- wr_en to word[5] and start in the same cycle -> plane 0 reflects the new word[5]. A write to word[5] during EMIT leaves later planes unchanged.
- rst=0 at plane 10 -> all outputs 0 immediately; no write_to_file. A fresh start then yields 25 planes of all-zero memory.
- With WORD_TRANSPOSER_HOLD_EN: hold=1 for 3 cycles at k=7 -> ldn low for 3 cycles, number stays 7, then continues; done at cycle 29.
